// File: rtl/down_count_timer.sv
// Loadable modulo down-counter with IDLE/RUN/PAUSED/DONE control and a terminal-count pulse.
// Define DOWN_COUNT_TIMER_AUTO_RELOAD_EN to reload and keep running at terminal count instead of stopping in DONE.
module down_count_timer #(
    parameter int N = 5,
    parameter int K = 20
) (
    input  logic         Clock,
    input  logic         Reset_n,
    input  logic         Load,
    input  logic [N-1:0] Din,
    input  logic         Start,
    input  logic         Pause,
    output logic [N-1:0] Q,
    output logic         Busy,
    output logic         Done,
    output logic         Tc
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [N-1:0] K_VAL = N'(K);
    localparam logic [N-1:0] ONE   = N'(1);
    localparam logic [N-1:0] ZERO  = '0;

    state_t         state_q, state_d;
    logic [N-1:0]   q_q, q_d;
    logic [N-1:0]   r_q, r_d;
    logic           tc_q, tc_d;
    logic [N-1:0]   load_val;
    logic           go;

    assign load_val = (Din > K_VAL) ? K_VAL : Din;
    assign go       = Start && !Pause;

    // Load overrides everything; otherwise Pause beats Start, and Q==0 preempts the decrement.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        tc_d    = 1'b0;
        if (Load) begin
            q_d     = load_val;
            r_d     = load_val;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go)
                        state_d = RUN;
                end
                RUN: begin
                    if (Pause) begin
                        state_d = PAUSED;
                    end else if (q_q != ZERO) begin
                        q_d = q_q - ONE;
                    end else begin
                        tc_d = 1'b1;
`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
                        q_d = r_q;
`else
                        state_d = DONE;
`endif
                    end
                end
                PAUSED: begin
                    if (go)
                        state_d = RUN;
                end
                DONE: begin
                    if (go) begin
                        q_d     = r_q;
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            q_q     <= K_VAL;
            r_q     <= K_VAL;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            tc_q    <= tc_d;
        end
    end

    assign Q    = q_q;
    assign Tc   = tc_q;
    assign Busy = (state_q == RUN);
    assign Done = (state_q == DONE);

endmodule

// File: tb/tb_down_count_timer.sv
// Randomized and directed checking of down_count_timer against a behavioural model.
module tb_down_count_timer;

    localparam int N = 5;
    localparam int K = 20;

    logic         Clock;
    logic         Reset_n;
    logic         Load;
    logic [N-1:0] Din;
    logic         Start;
    logic         Pause;
    logic [N-1:0] Q;
    logic         Busy;
    logic         Done;
    logic         Tc;

    int checks;
    int failures;

    // Behavioural model: a count, the reload value, and whether it is running or finished.
    int m_count;
    int m_reload;
    bit m_running;
    bit m_done;
    bit m_tc;

    down_count_timer #(.N(N), .K(K)) dut (
        .Clock  (Clock),
        .Reset_n(Reset_n),
        .Load   (Load),
        .Din    (Din),
        .Start  (Start),
        .Pause  (Pause),
        .Q      (Q),
        .Busy   (Busy),
        .Done   (Done),
        .Tc     (Tc)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_count   = K;
        m_reload  = K;
        m_running = 0;
        m_done    = 0;
        m_tc      = 0;
    endtask

    task automatic modelStep(input bit ld, input int din, input bit st, input bit ps);
        m_tc = 0;
        if (ld) begin
            m_count   = (din > K) ? K : din;
            m_reload  = m_count;
            m_running = 0;
            m_done    = 0;
        end else if (m_running) begin
            if (ps) begin
                m_running = 0;
            end else if (m_count > 0) begin
                m_count = m_count - 1;
            end else begin
                m_tc = 1;
`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
                m_count = m_reload;
`else
                m_running = 0;
                m_done    = 1;
`endif
            end
        end else if (st && !ps) begin
            if (m_done) begin
                m_count = m_reload;
                m_done  = 0;
            end
            m_running = 1;
        end
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, ".Q"}, int'(Q), m_count);
        checkOutput({tag, ".Busy"}, int'(Busy), int'(m_running));
        checkOutput({tag, ".Done"}, int'(Done), int'(m_done));
        checkOutput({tag, ".Tc"}, int'(Tc), int'(m_tc));
    endtask

    // Called at a falling edge: drive, clock once, update the model, then compare at the next falling edge.
    task automatic applyStimulus(input bit ld, input int din, input bit st, input bit ps, input string tag);
        Load  = ld;
        Din   = N'(din);
        Start = st;
        Pause = ps;
        @(posedge Clock);
        modelStep(ld, din, st, ps);
        @(negedge Clock);
        compareAll(tag);
    endtask

    task automatic runUntil(input int target, input string tag);
        int n;
        n = 0;
        while (m_count != target && n < 64) begin
            applyStimulus(0, 0, 1, 0, tag);
            n++;
        end
        checkOutput({tag, ".reached"}, m_count, target);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Reset_n  = 1'b0;
        Load     = 1'b0;
        Din      = '0;
        Start    = 1'b0;
        Pause    = 1'b0;
        modelReset();
        repeat (2) @(negedge Clock);
        compareAll("reset");
        Reset_n = 1'b1;

        // Count down from the reset value with Start held.
        applyStimulus(0, 0, 1, 0, "enter_run");
        checkOutput("enter_run.Q20", int'(Q), 20);
        checkOutput("enter_run.Busy1", int'(Busy), 1);
        for (int i = 0; i < 44; i++)
            applyStimulus(0, 0, 1, 0, "count20");

        // Saturating load, then a short count and a restart.
        applyStimulus(1, 31, 0, 0, "load31");
        checkOutput("load31.sat", int'(Q), 20);
        applyStimulus(1, 3, 0, 0, "load3");
        for (int i = 0; i < 8; i++)
            applyStimulus(0, 0, 1, 0, "count3");
        applyStimulus(0, 0, 0, 0, "idle3");
        applyStimulus(0, 0, 1, 0, "restart3");
        applyStimulus(0, 0, 1, 0, "restart3b");

        // Pause at 10 for four cycles, then resume.
        applyStimulus(1, 20, 0, 0, "load20");
        runUntil(10, "to10");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 1, "pause");
            checkOutput("pause.hold10", int'(Q), 10);
        end
        applyStimulus(0, 0, 1, 1, "pause_both");
        applyStimulus(0, 0, 1, 0, "resume");
        applyStimulus(0, 0, 1, 0, "resume2");
        checkOutput("resume.Q9", int'(Q), 9);

        // Load with Start while running.
        runUntil(12, "to12");
        if (m_count != 12) runUntil(12, "to12b");
        applyStimulus(1, 7, 1, 0, "load7start");
        checkOutput("load7start.Q", int'(Q), 7);
        checkOutput("load7start.Busy", int'(Busy), 0);

        // Asynchronous reset between edges at Q=5.
        runUntil(5, "to5");
        #2;
        Reset_n = 1'b0;
        #1;
        modelReset();
        compareAll("async_reset");
        checkOutput("async_reset.Q20", int'(Q), 20);
        @(negedge Clock);
        compareAll("reset_hold");
        Reset_n = 1'b1;

        // Zero load: terminal event right after the first RUN cycle.
        applyStimulus(1, 0, 0, 0, "load0");
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 0, 1, 0, "run0");

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit ld, st, ps;
            int din;
            ld  = ($urandom_range(0, 15) == 0);
            st  = ($urandom_range(0, 1) == 1);
            ps  = ($urandom_range(0, 4) == 0);
            din = $urandom_range(0, 31);
            applyStimulus(ld, din, st, ps, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
